// File: rtl/disp_arb_pkg.sv
// Shared types and constants for the display-sharing arbiter.
//   NREQ/IDW   : requester count and index width
//   BLANK_*    : pattern driven to the display mux when nobody owns it
//   state_e    : arbiter FSM states
//   disp_t     : registered payload sent to the display mux
package disp_arb_pkg;

  localparam int unsigned NREQ  = 4;
  localparam int unsigned IDW   = 2;
  localparam int unsigned HEXW  = 4;
  localparam int unsigned WORDW = NREQ * HEXW;

  localparam logic [HEXW-1:0] BLANK_DP  = 4'b1111;
  localparam logic [HEXW-1:0] BLANK_HEX = 4'h0;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_OWN  = 1'b1
  } state_e;

  typedef struct packed {
    logic [HEXW-1:0] hex3;
    logic [HEXW-1:0] hex2;
    logic [HEXW-1:0] hex1;
    logic [HEXW-1:0] hex0;
    logic [HEXW-1:0] dp;
  } disp_t;

  localparam disp_t BLANK_DISP = '{BLANK_HEX, BLANK_HEX, BLANK_HEX, BLANK_HEX, BLANK_DP};

  // One-hot grant vector for a requester index.
  function automatic logic [NREQ-1:0] onehot(input logic [IDW-1:0] idx);
    onehot = NREQ'(1) << idx;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first asserted req searching upward
// from ptr (mod NREQ), optionally skipping one excluded index.
//   req      : request vector
//   ptr      : search start index
//   excl_en  : enable exclusion of excl_idx
//   excl_idx : index to skip (current owner during preempt)
//   any      : a candidate was found
//   idx      : index of the candidate (ptr when none)
module rr_pick
  import disp_arb_pkg::*;
(
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  input  logic            excl_en,
  input  logic [IDW-1:0]  excl_idx,
  output logic            any,
  output logic [IDW-1:0]  idx
);

  logic [IDW-1:0] cand;

  // Rotating priority scan; IDW-bit addition wraps modulo NREQ.
  always_comb begin
    any  = 1'b0;
    idx  = ptr;
    cand = ptr;
    for (int unsigned k = 0; k < NREQ; k++) begin
      cand = ptr + IDW'(k);
      if (!any && req[cand] && !(excl_en && (cand == excl_idx))) begin
        any = 1'b1;
        idx = cand;
      end
    end
  end

endmodule

// File: rtl/disp_share_arb.sv
// Round-robin owner arbiter for the shared 4-digit seven-segment display.
//   clk, reset_n   : clock, synchronous active-low reset
//   req            : level-sensitive per-requester display request
//   data_in        : requester i hex word at [16i+15:16i]
//   dp_in_req      : requester i active-low dp pattern at [4i+3:4i]
//   gnt, owner_id  : one-hot grant and owner index (owner_id holds when idle)
//   hex3..hex0     : registered digit nibbles of the owner
//   dp_out, blank  : registered dp pattern, high blank when no owner
module disp_share_arb
  import disp_arb_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 50_000_000,
  parameter int unsigned CNT_W       = 26
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [NREQ-1:0]        req,
  input  logic [NREQ*WORDW-1:0]  data_in,
  input  logic [NREQ*HEXW-1:0]   dp_in_req,
  output logic [NREQ-1:0]        gnt,
  output logic [IDW-1:0]         owner_id,
  output logic [HEXW-1:0]        hex3,
  output logic [HEXW-1:0]        hex2,
  output logic [HEXW-1:0]        hex1,
  output logic [HEXW-1:0]        hex0,
  output logic [HEXW-1:0]        dp_out,
  output logic                   blank
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(HOLD_CYCLES - 1);

  state_e            state_q, state_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic [IDW-1:0]    owner_q, owner_d;
  logic [IDW-1:0]    ptr_q, ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  disp_t             disp_q, disp_d;
  logic              blank_q, blank_d;

  logic [WORDW-1:0]  words [NREQ];
  logic [HEXW-1:0]   dps   [NREQ];
  logic              pick_any;
  logic [IDW-1:0]    pick_idx;
  logic [IDW-1:0]    pick_ptr;
  logic              pick_excl;

  // Split the flat requester buses into per-requester words.
  always_comb begin
    for (int unsigned i = 0; i < NREQ; i++) begin
      words[i] = data_in[i*WORDW +: WORDW];
      dps[i]   = dp_in_req[i*HEXW +: HEXW];
    end
  end

  function automatic disp_t mk_disp(input logic [WORDW-1:0] w, input logic [HEXW-1:0] dp);
    mk_disp = '{w[15:12], w[11:8], w[7:4], w[3:0], dp};
  endfunction

  // In OWN the picker searches past the owner for a preempting requester.
  assign pick_excl = (state_q == ST_OWN);
  assign pick_ptr  = pick_excl ? (owner_q + IDW'(1)) : ptr_q;

  rr_pick u_rr_pick (
    .req      (req),
    .ptr      (pick_ptr),
    .excl_en  (pick_excl),
    .excl_idx (owner_q),
    .any      (pick_any),
    .idx      (pick_idx)
  );

  // Next-state, dwell counter and output payload.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    blank_d = blank_q;
    disp_d  = BLANK_DISP;
    case (state_q)
      ST_IDLE: begin
        gnt_d   = '0;
        blank_d = 1'b1;
        if (pick_any) begin
          state_d = ST_OWN;
          gnt_d   = onehot(pick_idx);
          owner_d = pick_idx;
          cnt_d   = '0;
          blank_d = 1'b0;
          disp_d  = mk_disp(words[pick_idx], dps[pick_idx]);
        end
      end
      ST_OWN: begin
        if (!req[owner_q]) begin
          // Release takes priority over any pending preempt.
          state_d = ST_IDLE;
          gnt_d   = '0;
          blank_d = 1'b1;
          ptr_d   = owner_q + IDW'(1);
        end else if ((cnt_q == CNT_MAX) && pick_any) begin
          gnt_d   = onehot(pick_idx);
          owner_d = pick_idx;
          cnt_d   = '0;
          ptr_d   = pick_idx + IDW'(1);
          disp_d  = mk_disp(words[pick_idx], dps[pick_idx]);
        end else begin
          if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
          disp_d = mk_disp(words[owner_q], dps[owner_q]);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      gnt_q   <= '0;
      owner_q <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      disp_q  <= BLANK_DISP;
      blank_q <= 1'b1;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      disp_q  <= disp_d;
      blank_q <= blank_d;
    end
  end

  assign gnt      = gnt_q;
  assign owner_id = owner_q;
  assign hex3     = disp_q.hex3;
  assign hex2     = disp_q.hex2;
  assign hex1     = disp_q.hex1;
  assign hex0     = disp_q.hex0;
  assign dp_out   = disp_q.dp;
  assign blank    = blank_q;

endmodule

// File: tb/tb_disp_share_arb.sv
// Self-checking bench for disp_share_arb (HOLD_CYCLES=8): directed scenarios
// plus randomized traffic against a behavioural owner/dwell model.
module tb_disp_share_arb;

  localparam int HOLD = 8;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [3:0]  req;
  logic [63:0] data_in;
  logic [15:0] dp_in_req;
  logic [3:0]  gnt;
  logic [1:0]  owner_id;
  logic [3:0]  hex3, hex2, hex1, hex0, dp_out;
  logic        blank;

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural model: who owns the display, for how long, where rr resumes.
  bit          m_busy;
  int          m_owner, m_ptr, m_held;
  logic [15:0] m_word;
  logic [3:0]  m_dp;

  always #5 clk = ~clk;

  disp_share_arb #(.HOLD_CYCLES(HOLD), .CNT_W(4)) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .data_in(data_in),
    .dp_in_req(dp_in_req), .gnt(gnt), .owner_id(owner_id),
    .hex3(hex3), .hex2(hex2), .hex1(hex1), .hex0(hex0),
    .dp_out(dp_out), .blank(blank)
  );

  task automatic model_step();
    bit found;
    int w;
    found = 0;
    w = 0;
    if (!reset_n) begin
      m_busy = 0; m_owner = 0; m_ptr = 0; m_held = 0;
    end else if (!m_busy) begin
      for (int k = 0; k < 4; k++)
        if (!found && req[(m_ptr + k) % 4]) begin found = 1; w = (m_ptr + k) % 4; end
      if (found) begin m_busy = 1; m_owner = w; m_held = 0; end
    end else if (!req[m_owner]) begin
      m_busy = 0;
      m_ptr  = (m_owner + 1) % 4;
    end else begin
      if (m_held == HOLD - 1)
        for (int k = 1; k < 4; k++)
          if (!found && req[(m_owner + k) % 4]) begin found = 1; w = (m_owner + k) % 4; end
      if (found) begin
        m_owner = w; m_held = 0; m_ptr = (w + 1) % 4;
      end else if (m_held < HOLD - 1) begin
        m_held++;
      end
    end
    if (m_busy) begin
      m_word = data_in[16*m_owner +: 16];
      m_dp   = dp_in_req[4*m_owner +: 4];
    end else begin
      m_word = 16'h0;
      m_dp   = 4'hF;
    end
  endtask

  // Advance one clock; model consumes the inputs seen at the edge.
  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    req     = 4'h0;
    repeat (2) tick();
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    req       = 4'hF;
    reset_n   = 1'b0;
    data_in   = {$urandom, $urandom};
    dp_in_req = 16'($urandom);
    for (int c = 0; c < 3; c++) begin
      tick();
      n_checks++;
      if ({gnt, owner_id, blank, dp_out, hex3, hex2, hex1, hex0} !== {4'h0, 2'd0, 1'b1, 4'hF, 16'h0}) begin
        n_errors++;
        $display("FAIL reset_vals cyc %0d: gnt=%b own=%0d blank=%b dp=%b hex=%h%h%h%h, want 0000/0/1/1111/0000",
                 c, gnt, owner_id, blank, dp_out, hex3, hex2, hex1, hex0);
      end
    end
    reset_n = 1'b1;
    tick();
    n_checks++;
    if (gnt !== 4'b0001) begin
      n_errors++;
      $display("FAIL reset_release_gnt: gnt=%b want 0001", gnt);
    end
  endtask

  task automatic test_single();
    do_reset();
    data_in   = {$urandom, $urandom};
    dp_in_req = 16'($urandom);
    data_in[47:32]  = 16'h1A2B;
    dp_in_req[11:8] = 4'b1011;
    req = 4'b0100;
    tick();
    n_checks++;
    if ({gnt, owner_id, blank, hex3, hex2, hex1, hex0, dp_out} !== {4'b0100, 2'd2, 1'b0, 16'h1A2B, 4'b1011}) begin
      n_errors++;
      $display("FAIL single_grant: gnt=%b own=%0d blank=%b hex=%h%h%h%h dp=%b, want 0100/2/0/1a2b/1011",
               gnt, owner_id, blank, hex3, hex2, hex1, hex0, dp_out);
    end
    for (int c = 0; c < 40; c++) begin
      tick();
      n_checks++;
      if (gnt !== 4'b0100) begin
        n_errors++;
        $display("FAIL single_hold cyc %0d: gnt=%b want 0100", c, gnt);
      end
    end
    data_in[47:32] = 16'h00FF;
    tick();
    n_checks++;
    if ({hex3, hex2, hex1, hex0} !== 16'h00FF) begin
      n_errors++;
      $display("FAIL single_data_follow: hex=%h%h%h%h want 00ff", hex3, hex2, hex1, hex0);
    end
  endtask

  task automatic test_rotation();
    do_reset();
    req = 4'b1111;
    tick();
    for (int o = 0; o < 5; o++) begin
      for (int c = 0; c < HOLD; c++) begin
        if (o != 0 || c != 0) tick();
        n_checks++;
        if ({gnt, owner_id, blank} !== {4'(1 << (o % 4)), 2'(o % 4), 1'b0}) begin
          n_errors++;
          $display("FAIL rotation o%0d c%0d: gnt=%b own=%0d blank=%b want %b/%0d/0",
                   o, c, gnt, owner_id, blank, 4'(1 << (o % 4)), o % 4);
        end
      end
    end
  endtask

  task automatic test_release();
    do_reset();
    req = 4'b0010;
    tick();
    repeat (3) tick();
    req = 4'b1000;
    tick();
    n_checks++;
    if ({gnt, blank} !== {4'b0000, 1'b1}) begin
      n_errors++;
      $display("FAIL release_idle: gnt=%b blank=%b want 0000/1", gnt, blank);
    end
    tick();
    n_checks++;
    if ({gnt, owner_id} !== {4'b1000, 2'd3}) begin
      n_errors++;
      $display("FAIL release_next: gnt=%b own=%0d want 1000/3", gnt, owner_id);
    end
  endtask

  task automatic test_release_vs_preempt();
    do_reset();
    req = 4'b0101;
    tick();
    repeat (HOLD - 1) tick();
    req = 4'b0100;
    tick();
    n_checks++;
    if ({gnt, blank} !== {4'b0000, 1'b1}) begin
      n_errors++;
      $display("FAIL relpre_idle: gnt=%b blank=%b want 0000/1", gnt, blank);
    end
    tick();
    n_checks++;
    if ({gnt, blank} !== {4'b0100, 1'b0}) begin
      n_errors++;
      $display("FAIL relpre_grant: gnt=%b blank=%b want 0100/0", gnt, blank);
    end
  endtask

  task automatic test_reset_mid_dwell();
    do_reset();
    req = 4'b0100;
    tick();
    req = 4'b0000;
    tick();
    req = 4'b1000;
    tick();
    repeat (5) tick();
    reset_n = 1'b0;
    tick();
    n_checks++;
    if ({gnt, owner_id, blank, dp_out, hex3, hex2, hex1, hex0} !== {4'h0, 2'd0, 1'b1, 4'hF, 16'h0}) begin
      n_errors++;
      $display("FAIL midreset_vals: gnt=%b own=%0d blank=%b dp=%b hex=%h%h%h%h want reset values",
               gnt, owner_id, blank, dp_out, hex3, hex2, hex1, hex0);
    end
    reset_n = 1'b1;
    req = 4'b1001;
    tick();
    n_checks++;
    if (gnt !== 4'b0001) begin
      n_errors++;
      $display("FAIL midreset_ptr: gnt=%b want 0001", gnt);
    end
  endtask

  task automatic test_random();
    logic [3:0] exp_gnt;
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      for (int b = 0; b < 4; b++)
        if ($urandom_range(0, 11) == 0) req[b] = ~req[b];
      data_in   = {$urandom, $urandom};
      dp_in_req = 16'($urandom);
      reset_n   = ($urandom_range(0, 299) != 0);
      tick();
      exp_gnt = m_busy ? 4'(1 << m_owner) : 4'h0;
      n_checks++;
      if ({gnt, owner_id, blank, hex3, hex2, hex1, hex0, dp_out} !== {exp_gnt, 2'(m_owner), !m_busy, m_word, m_dp}) begin
        n_errors++;
        $display("FAIL random cyc %0d: gnt=%b own=%0d blank=%b hex=%h%h%h%h dp=%b want %b/%0d/%b/%h/%b",
                 c, gnt, owner_id, blank, hex3, hex2, hex1, hex0, dp_out,
                 exp_gnt, m_owner, !m_busy, m_word, m_dp);
      end
      n_checks++;
      if (!$onehot0(gnt)) begin
        n_errors++;
        $display("FAIL random_onehot cyc %0d: gnt=%b want one-hot or zero", c, gnt);
      end
    end
  endtask

  initial begin
    reset_n   = 1'b0;
    req       = 4'h0;
    data_in   = '0;
    dp_in_req = '1;
    m_busy = 0; m_owner = 0; m_ptr = 0; m_held = 0; m_word = 16'h0; m_dp = 4'hF;
    test_reset();
    test_single();
    test_rotation();
    test_release();
    test_release_vs_preempt();
    test_reset_mid_dwell();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
